err_sig_ctrl: RTL

//  Error-signalling controller for the CAN-XL transmit path. Collects error detections, including bt_err

---
 rtl/err_sig_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/err_sig_ctrl.sv
// err_sig_ctrl - CAN-XL transmit-path error-signalling controller.
// Collects error detections, sequences error flag / dominant tolerance /
// delimiter / intermission, and owns TEC/REC fault confinement including
// bus-off recovery.
// Ports:
//   clk, g_rst_n        clock, async active-low reset
//   bit_tick            1-cycle pulse at each bit sample point
//   sampled_bit         bus value at sample point (1 = dominant)
//   tx_active           node is transmitter of the current frame
//   bt/stf/crc/frm/ack_err  error detections
//   tx_success, rx_success  error-free frame pulses
//   err_bus_drv         value driven onto the bus (1 = dominant)
//   act/psv_err_flg_tx  active/passive error flag in progress
//   cons_zero_flg       waiting for first recessive after the flag
//   ovld_err_ifs_tx     delimiter or intermission in progress
//   err_state           00 active, 01 passive, 10 bus-off
//   tec, rec            error counters
//   err_busy            sequencer not idle
module err_sig_ctrl #(
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8,
  parameter int IFS_LEN   = 3,
  parameter int PSV_LIM   = 128,
  parameter int BOFF_LIM  = 256,
  parameter int RECOV_SEQ = 128
) (
  input  logic       clk,
  input  logic       g_rst_n,
  input  logic       bit_tick,
  input  logic       sampled_bit,
  input  logic       tx_active,
  input  logic       bt_err,
  input  logic       stf_err,
  input  logic       crc_err,
  input  logic       frm_err,
  input  logic       ack_err,
  input  logic       tx_success,
  input  logic       rx_success,
  output logic       err_bus_drv,
  output logic       act_err_flg_tx,
  output logic       psv_err_flg_tx,
  output logic       cons_zero_flg,
  output logic       ovld_err_ifs_tx,
  output logic [1:0] err_state,
  output logic [8:0] tec,
  output logic [7:0] rec,
  output logic       err_busy
);

  localparam logic [1:0] ES_ACT  = 2'b00;
  localparam logic [1:0] ES_PSV  = 2'b01;
  localparam logic [1:0] ES_BOFF = 2'b10;
  localparam int SW = $clog2(RECOV_SEQ + 1);
  localparam logic [7:0]    FLAG_LAST  = 8'(FLAG_LEN - 1);
  localparam logic [7:0]    DELIM_LAST = 8'(DELIM_LEN - 1);
  localparam logic [7:0]    IFS_LAST   = 8'(IFS_LEN - 1);
  localparam logic [SW-1:0] SEQ_LAST   = SW'(RECOV_SEQ - 1);
  localparam logic [9:0]    BOFF_L     = 10'(BOFF_LIM);
  localparam logic [9:0]    PSV_L      = 10'(PSV_LIM);

  typedef enum logic [2:0] {S_IDLE, S_FLAG, S_WAIT, S_DELIM, S_IFS, S_BOFF} st_t;

  st_t           st, st_nxt;
  logic [7:0]    cnt, cnt_nxt;     // bit counter, meaning depends on state
  logic [SW-1:0] seq, seq_nxt;     // 11-recessive sequences seen in bus-off
  logic          pend, pend_ack, flag_psv;
  logic          start_flag, dom8, recover;
  logic [8:0]    tec_nxt;
  logic [7:0]    rec_nxt;
  logic [1:0]    es_nxt;
  logic [9:0]    tec_p8;
  logic [8:0]    rec_p8, rec_p1;

  wire err_any = bt_err | stf_err | crc_err | frm_err | ack_err;
  // an error in the tick cycle itself is honoured together with any pending one
  wire err_now = pend | err_any;
  wire ack_now = pend_ack | ack_err;

  // ---- state register ----
  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      st  <= S_IDLE;
      cnt <= '0;
      seq <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      seq <= seq_nxt;
    end
  end

  // ---- next-state ----
  always_comb begin
    st_nxt     = st;
    cnt_nxt    = cnt;
    seq_nxt    = seq;
    start_flag = 1'b0;
    dom8       = 1'b0;
    recover    = 1'b0;
    if (bit_tick) begin
      if (err_state == ES_BOFF && st != S_BOFF) begin
        // bus-off aborts whatever sequence is running
        st_nxt  = S_BOFF;
        cnt_nxt = '0;
        seq_nxt = '0;
      end else begin
        case (st)
          S_IDLE:  if (err_now) start_flag = 1'b1;
          S_FLAG:
            if (cnt == FLAG_LAST) begin
              st_nxt  = S_WAIT;
              cnt_nxt = '0;
            end else cnt_nxt = cnt + 8'd1;
          S_WAIT:
            if (sampled_bit) begin
              // cnt tracks consecutive dominant bits, penalty every 8th
              if (cnt == 8'd7) begin
                dom8    = 1'b1;
                cnt_nxt = '0;
              end else cnt_nxt = cnt + 8'd1;
            end else begin
              st_nxt  = S_DELIM;   // this recessive bit is delimiter bit 1
              cnt_nxt = 8'd1;
            end
          S_DELIM:
            if (sampled_bit || err_now) start_flag = 1'b1;
            else if (cnt == DELIM_LAST) begin
              st_nxt  = S_IFS;
              cnt_nxt = '0;
            end else cnt_nxt = cnt + 8'd1;
          S_IFS:
            if (cnt == IFS_LAST) begin
              st_nxt  = S_IDLE;
              cnt_nxt = '0;
            end else cnt_nxt = cnt + 8'd1;
          S_BOFF:
            if (sampled_bit) cnt_nxt = '0;
            else if (cnt == 8'd10) begin
              cnt_nxt = '0;
              if (seq == SEQ_LAST) begin
                recover = 1'b1;
                st_nxt  = S_IDLE;
                seq_nxt = '0;
              end else seq_nxt = seq + 1'b1;
            end else cnt_nxt = cnt + 8'd1;
          default: st_nxt = S_IDLE;
        endcase
        if (start_flag) begin
          st_nxt  = S_FLAG;
          cnt_nxt = '0;
        end
      end
    end
  end

  // ---- outputs (decoded from registered state) ----
  always_comb begin
    act_err_flg_tx  = (st == S_FLAG) && !flag_psv;
    psv_err_flg_tx  = (st == S_FLAG) &&  flag_psv;
    err_bus_drv     = act_err_flg_tx;
    cons_zero_flg   = (st == S_WAIT);
    ovld_err_ifs_tx = (st == S_DELIM) || (st == S_IFS);
    err_busy        = (st != S_IDLE);
  end

  // ---- fault confinement counters ----
  always_comb begin
    tec_p8  = {1'b0, tec} + 10'd8;
    rec_p8  = {1'b0, rec} + 9'd8;
    rec_p1  = {1'b0, rec} + 9'd1;
    tec_nxt = tec;
    rec_nxt = rec;
    if (recover) begin
      tec_nxt = '0;
      rec_nxt = '0;
    end else if (start_flag) begin
      if (tx_active) begin
        if (!(ack_now && err_state == ES_PSV))
          tec_nxt = tec_p8[9] ? 9'h1FF : tec_p8[8:0];
      end else rec_nxt = rec_p1[8] ? 8'hFF : rec_p1[7:0];
    end else if (dom8) begin
      if (tx_active) tec_nxt = tec_p8[9] ? 9'h1FF : tec_p8[8:0];
      else           rec_nxt = rec_p8[8] ? 8'hFF : rec_p8[7:0];
    end else if (!err_any && err_state != ES_BOFF) begin
      // success is dropped whenever an error lands in the same cycle
      if (tx_success && tec != 9'd0) tec_nxt = tec - 9'd1;
      if (rx_success) begin
        if (rec > 8'd127)     rec_nxt = 8'd119;
        else if (rec != 8'd0) rec_nxt = rec - 8'd1;
      end
    end
    if ({1'b0, tec_nxt} >= BOFF_L)                                es_nxt = ES_BOFF;
    else if ({1'b0, tec_nxt} >= PSV_L || {2'b0, rec_nxt} >= PSV_L) es_nxt = ES_PSV;
    else                                                          es_nxt = ES_ACT;
  end

  always_ff @(posedge clk or negedge g_rst_n) begin
    if (!g_rst_n) begin
      tec       <= '0;
      rec       <= '0;
      err_state <= ES_ACT;
      pend      <= 1'b0;
      pend_ack  <= 1'b0;
      flag_psv  <= 1'b0;
    end else begin
      tec       <= tec_nxt;
      rec       <= rec_nxt;
      err_state <= es_nxt;
      // flag type is frozen at flag start; later state changes wait for the next flag
      if (start_flag) flag_psv <= (err_state == ES_PSV);
      if (bit_tick) begin
        pend     <= 1'b0;
        pend_ack <= 1'b0;
      end else if ((st == S_IDLE || st == S_DELIM) && err_any) begin
        pend     <= 1'b1;
        pend_ack <= pend_ack | ack_err;
      end
    end
  end

endmodule
